wb_phyf_arbiter: RTL and testbench
==================================

// Module: wb_phyf_arbiter
// PURPOSE
//  Write-back producer for phy_regfile: drives wb_phyf_id/wb_phyf_data/wb_phyf_we.
//  Collects results from EU_NUM execution units over valid/ready handshakes.
//  Buffers each source in a small FIFO and round-robin arbitrates up to `WB_WIDTH writes per cycle.
//  Write-port outputs are registered. Sits between the execute stage and phy_regfile.
// PARAMETERS
//  EU_NUM        4   number of execution-unit result sources
//  FIFO_DEPTH    2   entries per source FIFO (power of two, >=2)
//  (widths from config: `WB_WIDTH, `PHY_REG_ID_WIDTH, `REG_DATA_WIDTH)
// PORTS
//  clk                  in   1                      clock, posedge
//  rst                  in   1                      asynchronous, active-low reset (0 = reset)
//  eu_wb_valid[EU_NUM]  in   1                      source holds a result
//  eu_wb_ready[EU_NUM]  out  1                      source FIFO can accept
//  eu_wb_rd_enable[EU_NUM] in 1                     result targets a destination register
//  eu_wb_phy_id[EU_NUM] in   `PHY_REG_ID_WIDTH      destination physical register
//  eu_wb_data[EU_NUM]   in   `REG_DATA_WIDTH        result value
//  wb_flush             in   1                      pipeline flush; discard all buffered results
//  wb_phyf_id[`WB_WIDTH]   out `PHY_REG_ID_WIDTH    write-port register id
//  wb_phyf_data[`WB_WIDTH] out `REG_DATA_WIDTH      write-port data
//  wb_phyf_we              out `WB_WIDTH            per-port write enable
// BEHAVIOUR
//  Reset (rst=0, async): FIFOs empty, rr_ptr=0, wb_phyf_we=0, wb_phyf_id=0, wb_phyf_data=0, eu_wb_ready=0.
//  Handshake: transfer on posedge when valid&&ready.
//   ready = !fifo_full && !wb_flush && rst. No pop-through: a full FIFO drops ready even while popping.
//  rd_enable=0 transfers are consumed (ready honoured) but never enqueued and never written.
//  Arbitration, each cycle:
//   - Scan sources cyclically from rr_ptr; grant the first `WB_WIDTH with non-empty FIFO.
//   - At most one grant per source per cycle. The k-th grant drives port k.
//   - Ungranted ports get we=0 and id/data held at their previous value.
//  Granted heads pop and load output registers at the same edge.
//  rr_ptr <= (last granted source + 1) mod EU_NUM; unchanged if no grant.
//  Latency (no bypass): accept at edge N -> entry visible on wb_phyf_* after edge N+1.
//  Flush: wb_flush=1 in cycle N -> at edge N, all FIFOs are cleared and we<=0.
//   Inputs in cycle N are not accepted. rr_ptr is preserved.
//  Ordering: per source FIFO order; no ordering guarantee across sources.
//  Simultaneous push and pop on a non-full FIFO: both occur; occupancy unchanged.
//  Pointer wrap: FIFO pointers are log2(FIFO_DEPTH)+1 bits. Full = MSB differs, rest equal.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//   - An incoming rd_enable result from a source with an empty FIFO competes in the same cycle's arbitration as if it were the head.
//   - If granted, it goes straight to the output register (latency 1 edge), skipping the FIFO.
//   - If not granted, it is enqueued normally.
//  WB_BYPASS_EN undefined: all results pass through the FIFO (latency 2 edges).
// STRUCTURE
//  Shared package wb_pkg: typedef wb_entry_t {phy_id, data}; localparam RR_PTR_WIDTH.
//  Sub-module wb_src_fifo (one per source, generate loop).
//   - Ports: push/pop, entry in/out, full/empty, flush.
//  Top level holds the round-robin grant logic and the output registers.
// TESTING
//  1. Reset mid-traffic: rst=0 while FIFOs hold entries -> we=0 and ready=0 immediately; after release, FIFOs are empty.
//  2. Single result: src0 phy_id=5, data=32'hDEADBEEF at edge N.
//     - no bypass: we[0]=1, id=5 after edge N+1, else we=0.
//     - with WB_BYPASS_EN: after edge N.
//  3. Contention, EU_NUM=4, WB_WIDTH=2, all four sources valid, rr_ptr=0:
//     - cycle A: grants src0->port0, src1->port1; rr_ptr=2.
//     - cycle B: grants src2, src3; rr_ptr=0.
//  4. Backpressure: src1 valid every cycle, never granted (others saturate ports) -> ready drops after FIFO_DEPTH=2 accepts; no entry lost or duplicated.
//  5. Flush: two entries buffered, wb_flush=1 -> next cycle we=0, FIFOs empty, no write of buffered ids.
//  6. rd_enable=0 with valid=1 -> ready=1, handshake completes, no wb_phyf_we ever asserted for it.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and widths for the write-back arbiter slice.
// Config widths default here when the build does not supply WB_WIDTH / PHY_REG_ID_WIDTH / REG_DATA_WIDTH.
`ifndef WB_WIDTH
`define WB_WIDTH 2
`endif
`ifndef PHY_REG_ID_WIDTH
`define PHY_REG_ID_WIDTH 6
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

package wb_pkg;

  localparam int unsigned EU_NUM_DEF = 4;

  typedef struct packed {
    logic [`PHY_REG_ID_WIDTH-1:0] phy_id;
    logic [`REG_DATA_WIDTH-1:0]   data;
  } wb_entry_t;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned RR_PTR_WIDTH = ptr_width(EU_NUM_DEF);

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO; pointers carry one extra wrap bit to tell full from empty.
module wb_src_fifo
  import wb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  logic      pop_i,
  input  logic      flush_i,
  input  wb_entry_t entry_i,
  output wb_entry_t entry_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  wb_entry_t   mem_q [Depth];
  logic        do_push, do_pop;

  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    entry_o = mem_q[rd_q[AW-1:0]];
    do_push = push_i && !full_o && !flush_i;
    do_pop  = pop_i && !empty_o && !flush_i;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= entry_i;
  end

endmodule

// File: rtl/wb_phyf_arbiter.sv
// Write-back arbiter: buffers EU results per source and round-robin grants up to WB_WIDTH
// registered phy_regfile writes per cycle. Optional same-cycle bypass: WB_BYPASS_EN.
module wb_phyf_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned EU_NUM     = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [EU_NUM-1:0]            eu_wb_valid,
  output logic [EU_NUM-1:0]            eu_wb_ready,
  input  logic [EU_NUM-1:0]            eu_wb_rd_enable,
  input  logic [`PHY_REG_ID_WIDTH-1:0] eu_wb_phy_id [EU_NUM],
  input  logic [`REG_DATA_WIDTH-1:0]   eu_wb_data   [EU_NUM],
  input  logic                         wb_flush,
  output logic [`PHY_REG_ID_WIDTH-1:0] wb_phyf_id   [`WB_WIDTH],
  output logic [`REG_DATA_WIDTH-1:0]   wb_phyf_data [`WB_WIDTH],
  output logic [`WB_WIDTH-1:0]         wb_phyf_we
);

  localparam int unsigned WbW = `WB_WIDTH;
  localparam int unsigned RrW = ptr_width(EU_NUM);

  logic [EU_NUM-1:0] full, empty, xfer, push, pop, cand, grant, byp_cand;
  wb_entry_t         in_entry [EU_NUM];
  wb_entry_t         head     [EU_NUM];
  logic [RrW-1:0]    rr_q, rr_d;
  logic [WbW-1:0]    we_q, we_d;
  wb_entry_t         out_q [WbW];
  wb_entry_t         out_d [WbW];

  always_comb begin
    for (int unsigned s = 0; s < EU_NUM; s++) begin
      eu_wb_ready[s]     = !full[s] && !wb_flush && rst;
      in_entry[s].phy_id = eu_wb_phy_id[s];
      in_entry[s].data   = eu_wb_data[s];
    end
    xfer = eu_wb_valid & eu_wb_ready;
  end

`ifdef WB_BYPASS_EN
  assign byp_cand = xfer & eu_wb_rd_enable & empty;
`else
  assign byp_cand = '0;
`endif

  assign cand = ~empty | byp_cand;

  always_comb begin
    int unsigned src;
    int unsigned n;
    grant = '0;
    we_d  = '0;
    out_d = out_q;
    rr_d  = rr_q;
    n     = 0;
    src   = 0;
    for (int unsigned i = 0; i < EU_NUM; i++) begin
      src = (32'(rr_q) + i) % EU_NUM;
      if (cand[src] && (n < WbW)) begin
        grant[src] = 1'b1;
        we_d[n]    = 1'b1;
        // An empty source can only be a candidate through the bypass path.
        out_d[n]   = empty[src] ? in_entry[src] : head[src];
        rr_d       = RrW'((src + 1) % EU_NUM);
        n          = n + 1;
      end
    end
    if (wb_flush) begin
      grant = '0;
      we_d  = '0;
      out_d = out_q;
      rr_d  = rr_q;
    end
  end

  assign push = xfer & eu_wb_rd_enable & ~(grant & byp_cand);
  assign pop  = grant & ~empty;

  for (genvar g = 0; g < EU_NUM; g++) begin : g_src
    wb_src_fifo #(
      .Depth (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .flush_i (wb_flush),
      .entry_i (in_entry[g]),
      .entry_o (head[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q  <= '0;
      we_q  <= '0;
      out_q <= '{default: '0};
    end else begin
      rr_q  <= rr_d;
      we_q  <= we_d;
      out_q <= out_d;
    end
  end

  always_comb begin
    wb_phyf_we = we_q;
    for (int unsigned k = 0; k < WbW; k++) begin
      wb_phyf_id[k]   = out_q[k].phy_id;
      wb_phyf_data[k] = out_q[k].data;
    end
  end

endmodule

// File: tb/tb_wb_phyf_arbiter.sv
// Self-checking bench for wb_phyf_arbiter (default build: no bypass, EU_NUM=4, WB_WIDTH=2).
`timescale 1ns/1ps
module tb_wb_phyf_arbiter;

  localparam int unsigned EU  = 4;
  localparam int unsigned WB  = `WB_WIDTH;
  localparam int unsigned IDW = `PHY_REG_ID_WIDTH;
  localparam int unsigned DW  = `REG_DATA_WIDTH;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [EU-1:0]  valid = '0;
  logic [EU-1:0]  ready;
  logic [EU-1:0]  rd_en = '0;
  logic [IDW-1:0] ids [EU];
  logic [DW-1:0]  dat [EU];
  logic           flush = 1'b0;
  logic [IDW-1:0] out_id   [WB];
  logic [DW-1:0]  out_data [WB];
  logic [WB-1:0]  we;

  wb_phyf_arbiter #(
    .EU_NUM     (EU),
    .FIFO_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .eu_wb_valid     (valid),
    .eu_wb_ready     (ready),
    .eu_wb_rd_enable (rd_en),
    .eu_wb_phy_id    (ids),
    .eu_wb_data      (dat),
    .wb_flush        (flush),
    .wb_phyf_id      (out_id),
    .wb_phyf_data    (out_data),
    .wb_phyf_we      (we)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    int             src;
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } sb_t;
  sb_t sbq[$];

  logic [3:0] seq [EU];

  typedef struct {
    logic [3:0] v;
    logic [3:0] rd;
    logic       f;
    logic [3:0] rdy;
    logic [1:0] we;
    int         p0;
  } vec_t;
  vec_t tbl [25];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Match a write on port k against the oldest outstanding result of the same source.
  task automatic sb_match(input int k);
    int idx;
    int s;
    idx = -1;
    s   = int'(out_id[k][IDW-1:IDW-2]);
    foreach (sbq[i]) if (idx < 0 && sbq[i].src == s) idx = i;
    checks++;
    if (idx < 0) begin
      errs++;
      $display("FAIL sb_port%0d: got write id=%0h data=%0h required no write", k, out_id[k],
               out_data[k]);
    end else begin
      if (sbq[idx].id !== out_id[k] || sbq[idx].data !== out_data[k]) begin
        errs++;
        $display("FAIL sb_port%0d: got id=%0h data=%0h required id=%0h data=%0h", k, out_id[k],
                 out_data[k], sbq[idx].id, sbq[idx].data);
      end
      sbq.delete(idx);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] r, input logic f);
    valid = v;
    rd_en = r;
    flush = f;
    for (int s = 0; s < EU; s++) begin
      if (v[s]) begin
        ids[s] = {2'(s), seq[s]};
        dat[s] = $urandom;
        seq[s] = seq[s] + 4'd1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < WB; k++) if (we[k]) sb_match(k);
    for (int s = 0; s < EU; s++)
      if (valid[s] && ready[s] && rd_en[s]) sbq.push_back('{src: s, id: ids[s], data: dat[s]});
    if (flush) sbq.delete();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int s = 0; s < EU; s++) begin
      ids[s] = '0;
      dat[s] = '0;
      seq[s] = '0;
    end
    // src order in masks: bit0 = src0
    tbl[0]  = '{4'hF, 4'hF, 1'b0, 4'hF, 2'b00, -1};
    tbl[1]  = '{4'hF, 4'hF, 1'b0, 4'hF, 2'b00, -1};
    tbl[2]  = '{4'hF, 4'hF, 1'b0, 4'h3, 2'b11, 0};
    tbl[3]  = '{4'hF, 4'hF, 1'b0, 4'hC, 2'b11, 2};
    tbl[4]  = '{4'hF, 4'hF, 1'b0, 4'h3, 2'b11, 0};
    tbl[5]  = '{4'hF, 4'hF, 1'b0, 4'hC, 2'b11, 2};
    tbl[6]  = '{4'h0, 4'hF, 1'b0, 4'h3, 2'b11, 0};
    tbl[7]  = '{4'h0, 4'hF, 1'b0, 4'hF, 2'b11, 2};
    tbl[8]  = '{4'h0, 4'hF, 1'b0, 4'hF, 2'b11, 0};
    tbl[9]  = '{4'h0, 4'hF, 1'b0, 4'hF, 2'b11, 2};
    tbl[10] = '{4'h4, 4'hB, 1'b0, 4'hF, 2'b00, -1};
    tbl[11] = '{4'h0, 4'hF, 1'b0, 4'hF, 2'b00, -1};
    tbl[12] = '{4'h0, 4'hF, 1'b0, 4'hF, 2'b00, -1};
    tbl[13] = '{4'h1, 4'hF, 1'b0, 4'hF, 2'b00, -1};
    tbl[14] = '{4'h0, 4'hF, 1'b0, 4'hF, 2'b00, -1};
    tbl[15] = '{4'h0, 4'hF, 1'b0, 4'hF, 2'b01, 0};
    tbl[16] = '{4'h6, 4'hF, 1'b0, 4'hF, 2'b00, -1};
    tbl[17] = '{4'h9, 4'hF, 1'b1, 4'h0, 2'b00, -1};
    tbl[18] = '{4'h0, 4'hF, 1'b0, 4'hF, 2'b00, -1};
    tbl[19] = '{4'h0, 4'hF, 1'b0, 4'hF, 2'b00, -1};
    tbl[20] = '{4'hF, 4'hF, 1'b0, 4'hF, 2'b00, -1};
    tbl[21] = '{4'h0, 4'hF, 1'b0, 4'hF, 2'b00, -1};
    tbl[22] = '{4'h0, 4'hF, 1'b0, 4'hF, 2'b11, 1};
    tbl[23] = '{4'h0, 4'hF, 1'b0, 4'hF, 2'b11, 3};
    tbl[24] = '{4'h0, 4'hF, 1'b0, 4'hF, 2'b00, -1};

    // Reset state
    #2;
    chk("rst_we", we, 0);
    chk("rst_ready", ready, 0);
    chk("rst_id0", out_id[0], 0);
    chk("rst_data1", out_data[1], 0);
    @(negedge clk);
    rst = 1'b1;
    advance();

    // Contention from rr_ptr=0: src0/src1 first, then src2/src3
    drive(4'hF, 4'hF, 1'b0);
    sample();
    chk("cont_ready", ready, 4'hF);
    advance();
    drive(4'h0, 4'h0, 1'b0);
    sample();
    chk("cont_we_edge_n", we, 2'b00);
    advance();
    sample();
    chk("cont_a_we", we, 2'b11);
    chk("cont_a_id0", out_id[0], 6'h00);
    chk("cont_a_id1", out_id[1], 6'h10);
    advance();
    sample();
    chk("cont_b_we", we, 2'b11);
    chk("cont_b_id0", out_id[0], 6'h20);
    chk("cont_b_id1", out_id[1], 6'h30);
    advance();
    sample();
    chk("cont_idle_we", we, 2'b00);
    advance();

    // Single result, two-edge latency
    drive(4'h1, 4'h1, 1'b0);
    ids[0] = 6'h05;
    dat[0] = 32'hDEADBEEF;
    sample();
    chk("single_ready", ready[0], 1'b1);
    advance();
    drive(4'h0, 4'h0, 1'b0);
    sample();
    chk("single_we_n", we, 2'b00);
    advance();
    sample();
    chk("single_we_n1", we, 2'b01);
    chk("single_id", out_id[0], 6'h05);
    chk("single_data", out_data[0], 32'hDEADBEEF);
    advance();
    sample();
    chk("single_we_after", we, 2'b00);
    advance();

    // Reset while FIFOs hold entries
    drive(4'hF, 4'hF, 1'b0);
    sample();
    advance();
    drive(4'hF, 4'hF, 1'b0);
    sample();
    advance();
    rst = 1'b0;
    #1;
    chk("midrst_we", we, 2'b00);
    chk("midrst_ready", ready, 4'h0);
    chk("midrst_id1", out_id[1], 0);
    sbq.delete();
    drive(4'h0, 4'h0, 1'b0);
    sample();
    rst = 1'b1;
    advance();
    sample();
    chk("postrst_ready", ready, 4'hF);
    chk("postrst_we0", we, 2'b00);
    advance();
    for (int i = 0; i < 2; i++) begin
      sample();
      chk($sformatf("postrst_we%0d", i + 1), we, 2'b00);
      advance();
    end

    // Backpressure, rd_enable=0, round-robin resume and flush vectors
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].v, tbl[i].rd, tbl[i].f);
      sample();
      chk($sformatf("row%0d_ready", i), ready, tbl[i].rdy);
      chk($sformatf("row%0d_we", i), we, tbl[i].we);
      if (tbl[i].p0 >= 0) chk($sformatf("row%0d_p0src", i), out_id[0][IDW-1:IDW-2], tbl[i].p0);
      advance();
    end
    drive(4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample();
      advance();
    end
    chk("sb_drain", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
